// File: rtl/bcd_counter_10000.sv
// Four-digit BCD up/down counter with a binary mirror, a wrap pulse and an optional
// common-anode FND scanner enabled by the FND_SCAN_EN macro (tied off when undefined).
module bcd_counter_10000 #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_tick,
  input  logic                  i_clear,
  input  logic                  i_mode,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [13:0]           o_count_bin,
  output logic                  o_wrap,
  output logic [3:0]            o_fnd_com,
  output logic [7:0]            o_fnd_data
);

  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};
  localparam logic [13:0]         BIN_MAX   = 14'd9999;

  if (DIGITS != 4) begin : g_bad_digits
    $error("bcd_counter_10000: DIGITS must be 4");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("bcd_counter_10000: SCAN_DIV must be >= 2");
  end

  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [13:0]         bin_q, bin_d;
  logic                wrap_q, wrap_d;

  // Clear beats tick; the binary mirror steps in lockstep with the BCD digits.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    bcd_d  = bcd_q;
    bin_d  = bin_q;
    wrap_d = 1'b0;
    carry  = 1'b1;
    dig    = 4'd0;
    if (i_clear) begin
      bcd_d = '0;
      bin_d = '0;
    end else if (i_tick) begin
      if (!i_mode) begin
        if (bcd_q == ALL_NINES) begin
          bcd_d  = '0;
          bin_d  = '0;
          wrap_d = 1'b1;
        end else begin
          bin_d = bin_q + 14'd1;
          for (int i = 0; i < DIGITS; i++) begin
            dig = bcd_q[4*i +: 4];
            if (carry) begin
              if (dig == 4'd9) begin
                bcd_d[4*i +: 4] = 4'd0;
              end else begin
                bcd_d[4*i +: 4] = dig + 4'd1;
                carry = 1'b0;
              end
            end
          end
        end
      end else begin
        if (bcd_q == '0) begin
          bcd_d  = ALL_NINES;
          bin_d  = BIN_MAX;
          wrap_d = 1'b1;
        end else begin
          bin_d = bin_q - 14'd1;
          for (int i = 0; i < DIGITS; i++) begin
            dig = bcd_q[4*i +: 4];
            if (carry) begin
              if (dig == 4'd0) begin
                bcd_d[4*i +: 4] = 4'd9;
              end else begin
                bcd_d[4*i +: 4] = dig - 4'd1;
                carry = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      bin_q  <= bin_d;
      wrap_q <= wrap_d;
    end
  end

  assign o_bcd       = bcd_q;
  assign o_count_bin = bin_q;
  assign o_wrap      = wrap_q;

`ifdef FND_SCAN_EN
  localparam int SCAN_W = $clog2(SCAN_DIV);

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        com_q, com_d;
  logic [7:0]        seg_q, seg_d;
  logic [3:0]        cur_dig;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Enables and segments are both built from the next index and next count, so they stay aligned.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
    com_d   = ~(4'b0001 << idx_d);
    cur_dig = bcd_d[{idx_d, 2'b00} +: 4];
    seg_d   = seg7(cur_dig);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt_q <= '0;
      idx_q      <= 2'd0;
      com_q      <= 4'b1111;
      seg_q      <= 8'hFF;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      com_q      <= com_d;
      seg_q      <= seg_d;
    end
  end

  assign o_fnd_com  = com_q;
  assign o_fnd_data = seg_q;
`else
  assign o_fnd_com  = 4'b1111;
  assign o_fnd_data = 8'hFF;
`endif

endmodule

// File: tb/tb_bcd_counter_10000.sv
// Bench for bcd_counter_10000: integer reference model feeding an expected queue, one task per scenario.
module tb_bcd_counter_10000;

  logic        clk;
  logic        rst;
  logic        i_tick;
  logic        i_clear;
  logic        i_mode;
  logic [15:0] o_bcd;
  logic [13:0] o_count_bin;
  logic        o_wrap;
  logic [3:0]  o_fnd_com;
  logic [7:0]  o_fnd_data;

  logic [30:0] exp_q[$];
  int          model_cnt;
  int          errors;
  int          checks;
  int          wrap_seen;

  bcd_counter_10000 #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_tick     (i_tick),
    .i_clear    (i_clear),
    .i_mode     (i_mode),
    .o_bcd      (o_bcd),
    .o_count_bin(o_count_bin),
    .o_wrap     (o_wrap),
    .o_fnd_com  (o_fnd_com),
    .o_fnd_data (o_fnd_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Driver: called at a negedge; applies inputs, pushes the model result, compares after the edge.
  task automatic step(input logic t, input logic c, input logic m, input logic r, input string name);
    logic        exp_wrap;
    logic [30:0] exp;
    logic [30:0] got;
    i_tick  = t;
    i_clear = c;
    i_mode  = m;
    rst     = r;
    exp_wrap = 1'b0;
    if (!r || c) begin
      model_cnt = 0;
    end else if (t) begin
      if (!m) begin
        if (model_cnt == 9999) begin
          model_cnt = 0;
          exp_wrap  = 1'b1;
        end else begin
          model_cnt = model_cnt + 1;
        end
      end else begin
        if (model_cnt == 0) begin
          model_cnt = 9999;
          exp_wrap  = 1'b1;
        end else begin
          model_cnt = model_cnt - 1;
        end
      end
    end
    exp_q.push_back({exp_wrap, 14'(model_cnt), to_bcd(model_cnt)});
    @(posedge clk);
    @(negedge clk);
    exp = exp_q.pop_front();
    got = {o_wrap, o_count_bin, o_bcd};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got wrap=%b bin=%0d bcd=%h, expected wrap=%b bin=%0d bcd=%h",
               name, got[30], got[29:16], got[15:0], exp[30], exp[29:16], exp[15:0]);
    end
    if (o_wrap === 1'b1) wrap_seen++;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, "reset_count");
      checks++;
      if (o_fnd_com !== 4'b1111 || o_fnd_data !== 8'hFF) begin
        errors++;
        $display("FAIL reset_fnd: got com=%b data=%h, expected com=1111 data=ff", o_fnd_com, o_fnd_data);
      end
    end
  endtask

  task automatic test_up_wrap;
    wrap_seen = 0;
    for (int i = 0; i < 10000; i++) step(1'b1, 1'b0, 1'b0, 1'b1, "up_wrap");
    step(1'b0, 1'b0, 1'b0, 1'b1, "up_wrap_hold");
    checks++;
    if (wrap_seen !== 1) begin
      errors++;
      $display("FAIL up_wrap_pulses: got %0d pulses, expected 1", wrap_seen);
    end
  endtask

  task automatic test_down_wrap;
    step(1'b0, 1'b0, 1'b1, 1'b1, "mode_only_hold");
    step(1'b1, 1'b0, 1'b1, 1'b1, "down_wrap");
    step(1'b1, 1'b0, 1'b1, 1'b1, "down_after_wrap");
    step(1'b0, 1'b0, 1'b0, 1'b1, "mode_flip_hold");
    step(1'b0, 1'b0, 1'b1, 1'b1, "mode_flip_hold2");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 1'b1, "down_run");
  endtask

  task automatic test_clear_vs_tick;
    step(1'b0, 1'b1, 1'b0, 1'b1, "clear_only");
    for (int i = 0; i < 42; i++) step(1'b1, 1'b0, 1'b0, 1'b1, "to_0042");
    step(1'b1, 1'b1, 1'b0, 1'b1, "clear_tick_0042");
    step(1'b1, 1'b0, 1'b1, 1'b1, "to_9999");
    step(1'b1, 1'b1, 1'b0, 1'b1, "clear_tick_9999");
    step(1'b0, 1'b0, 1'b0, 1'b1, "after_clear_hold");
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 137; i++) step(1'b1, 1'b0, 1'b0, 1'b1, "to_0137");
    step(1'b1, 1'b0, 1'b0, 1'b0, "reset_mid");
    step(1'b1, 1'b0, 1'b0, 1'b1, "resume_after_reset");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 1'b1, "random");
  endtask

  task automatic test_fnd;
    logic [3:0] prev;
    logic [3:0] exp_com;
    logic [7:0] exp_data;
    logic [7:0] fnd_exp [0:3];
    logic       found;
    fnd_exp[0] = 8'h99;
    fnd_exp[1] = 8'hB0;
    fnd_exp[2] = 8'hA4;
    fnd_exp[3] = 8'hF9;
    step(1'b0, 1'b1, 1'b0, 1'b1, "fnd_clear");
    for (int i = 0; i < 1234; i++) step(1'b1, 1'b0, 1'b0, 1'b1, "to_1234");
`ifdef FND_SCAN_EN
    found = 1'b0;
    prev  = o_fnd_com;
    for (int i = 0; i < 24 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, "fnd_sync");
      if (o_fnd_com === 4'b1110 && prev === 4'b0111) found = 1'b1;
      else prev = o_fnd_com;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL fnd_sync: got com=%b, expected slot change 0111->1110 within 24 cycles", o_fnd_com);
    end else begin
      for (int s = 0; s < 4; s++) begin
        for (int k = 0; k < 4; k++) begin
          if (s != 0 || k != 0) step(1'b0, 1'b0, 1'b0, 1'b1, "fnd_scan");
          exp_com  = 4'b1111 ^ (4'b0001 << s);
          exp_data = fnd_exp[s];
          checks++;
          if (o_fnd_com !== exp_com || o_fnd_data !== exp_data) begin
            errors++;
            $display("FAIL fnd_slot%0d: got com=%b data=%h, expected com=%b data=%h",
                     s, o_fnd_com, o_fnd_data, exp_com, exp_data);
          end
        end
      end
    end
`else
    prev     = 4'b1111;
    found    = 1'b0;
    exp_com  = prev;
    exp_data = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, "fnd_tied");
      checks++;
      if (o_fnd_com !== exp_com || o_fnd_data !== exp_data) begin
        errors++;
        $display("FAIL fnd_tied: got com=%b data=%h, expected com=%b data=%h",
                 o_fnd_com, o_fnd_data, exp_com, exp_data);
      end
    end
`endif
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    model_cnt = 0;
    wrap_seen = 0;
    rst       = 1'b0;
    i_tick    = 1'b0;
    i_clear   = 1'b0;
    i_mode    = 1'b0;
    @(negedge clk);
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_clear_vs_tick();
    test_reset_mid();
    test_back_to_back();
    test_fnd();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
